// File: rtl/core_pkg.sv
// Shared definitions for the 5-stage core hazard logic.
// Register address width, forwarding select codes and mul/div FSM states.
package core_pkg;

    localparam int REG_AW = 5;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_t;

endpackage

// File: rtl/md_seq.sv
// Mul/div sequencer: holds an E-stage mul/div for MD_LATENCY stall cycles.
// Ports: clk, reset_n, md_start (in); md_stall, md_busy, md_done (out).
module md_seq
    import core_pkg::*;
#(
    parameter int MD_LATENCY = 32,
    parameter int CNT_W      = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic md_start,
    output logic md_stall,
    output logic md_busy,
    output logic md_done
);

    if (MD_LATENCY < 2 || MD_LATENCY > 255 ||
        (2 ** CNT_W) <= MD_LATENCY) begin : g_bad_cfg
        $error("md_seq: illegal MD_LATENCY/CNT_W");
    end

    md_state_t        state;
    md_state_t        state_n;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= MD_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // The detecting IDLE cycle already stalls, so BUSY runs
    // MD_LATENCY-1 cycles for a total of MD_LATENCY stalls.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        md_stall = 1'b0;
        md_done  = 1'b0;
        unique case (state)
            MD_IDLE: begin
                if (md_start) begin
                    md_stall = 1'b1;
                    state_n  = MD_BUSY;
                    cnt_n    = CNT_W'(MD_LATENCY - 1);
                end
            end
            MD_BUSY: begin
                md_stall = 1'b1;
                cnt_n    = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    state_n = MD_DONE;
                end
            end
            MD_DONE: begin
                md_done = 1'b1;
                state_n = MD_IDLE;
            end
            default: begin
                state_n = MD_IDLE;
            end
        endcase
    end

    assign md_busy = (state != MD_IDLE);

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller: forwarding selects, load-use/branch/mul-div stall+flush.
// Ports: D/E/M/W regs and hazard flags in; forward_*, stall_*, flush_*,
// md_busy, md_done out. `HAZARD_PERF_EN adds stall_cnt/flush_cnt/md_op_cnt.
module hazard_ctrl #(
    parameter int REG_AW     = core_pkg::REG_AW,
    parameter int MD_LATENCY = 32,
    parameter int CNT_W      = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [REG_AW-1:0] rs1_d,
    input  logic [REG_AW-1:0] rs2_d,
    input  logic [REG_AW-1:0] rs1_e,
    input  logic [REG_AW-1:0] rs2_e,
    input  logic [REG_AW-1:0] rd_e,
    input  logic [REG_AW-1:0] rd_m,
    input  logic [REG_AW-1:0] rd_w,
    input  logic              load_e,
    input  logic              regwrite_m,
    input  logic              regwrite_w,
    input  logic              pcsrc_e,
    input  logic              md_start_e,
    output logic [1:0]        forward_ae,
    output logic [1:0]        forward_be,
    output logic              stall_f,
    output logic              stall_d,
    output logic              stall_e,
    output logic              flush_d,
    output logic              flush_e,
    output logic              flush_m,
    output logic              md_busy,
    output logic              md_done
`ifdef HAZARD_PERF_EN
   ,output logic [31:0]       stall_cnt,
    output logic [31:0]       flush_cnt,
    output logic [31:0]       md_op_cnt
`endif
);

    import core_pkg::*;

    logic m_hit_a;
    logic m_hit_b;
    logic w_hit_a;
    logic w_hit_b;
    logic lw_stall;
    logic md_stall;

    assign m_hit_a = regwrite_m && (rd_m != '0) && (rd_m == rs1_e);
    assign m_hit_b = regwrite_m && (rd_m != '0) && (rd_m == rs2_e);
    assign w_hit_a = regwrite_w && (rd_w != '0) && (rd_w == rs1_e);
    assign w_hit_b = regwrite_w && (rd_w != '0) && (rd_w == rs2_e);

    // M is the younger producer, so it wins over W.
    always_comb begin
        forward_ae = FWD_RF;
        if (m_hit_a) begin
            forward_ae = FWD_MEM;
        end else if (w_hit_a) begin
            forward_ae = FWD_WB;
        end
    end

    always_comb begin
        forward_be = FWD_RF;
        if (m_hit_b) begin
            forward_be = FWD_MEM;
        end else if (w_hit_b) begin
            forward_be = FWD_WB;
        end
    end

    assign lw_stall = load_e && (rd_e != '0) &&
                      ((rd_e == rs1_d) || (rd_e == rs2_d));

    md_seq #(
        .MD_LATENCY (MD_LATENCY),
        .CNT_W      (CNT_W)
    ) u_md_seq (
        .clk      (clk),
        .reset_n  (reset_n),
        .md_start (md_start_e),
        .md_stall (md_stall),
        .md_busy  (md_busy),
        .md_done  (md_done)
    );

    // E must hold an in-flight mul/div, so md_stall masks the
    // load-use bubble into E.
    assign stall_f = lw_stall | md_stall;
    assign stall_d = lw_stall | md_stall;
    assign stall_e = md_stall;
    assign flush_d = pcsrc_e;
    assign flush_e = pcsrc_e | (lw_stall & ~md_stall);
    assign flush_m = md_stall;

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
            md_op_cnt <= '0;
        end else begin
            if (stall_f) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (flush_d | flush_e | flush_m) begin
                flush_cnt <= flush_cnt + 32'd1;
            end
            if (md_done) begin
                md_op_cnt <= md_op_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl with MD_LATENCY=4.
// Driver queues expected outputs per cycle; negedge monitor checks them.
module tb_hazard_ctrl;

    logic       clk;
    logic       reset_n;
    logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic       load_e, regwrite_m, regwrite_w, pcsrc_e, md_start_e;
    logic [1:0] forward_ae, forward_be;
    logic       stall_f, stall_d, stall_e;
    logic       flush_d, flush_e, flush_m;
    logic       md_busy, md_done;
`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt, flush_cnt, md_op_cnt;
`endif

    hazard_ctrl #(
        .REG_AW     (5),
        .MD_LATENCY (4),
        .CNT_W      (8)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .rs1_d      (rs1_d),
        .rs2_d      (rs2_d),
        .rs1_e      (rs1_e),
        .rs2_e      (rs2_e),
        .rd_e       (rd_e),
        .rd_m       (rd_m),
        .rd_w       (rd_w),
        .load_e     (load_e),
        .regwrite_m (regwrite_m),
        .regwrite_w (regwrite_w),
        .pcsrc_e    (pcsrc_e),
        .md_start_e (md_start_e),
        .forward_ae (forward_ae),
        .forward_be (forward_be),
        .stall_f    (stall_f),
        .stall_d    (stall_d),
        .stall_e    (stall_e),
        .flush_d    (flush_d),
        .flush_e    (flush_e),
        .flush_m    (flush_m),
        .md_busy    (md_busy),
        .md_done    (md_done)
`ifdef HAZARD_PERF_EN
       ,.stall_cnt  (stall_cnt),
        .flush_cnt  (flush_cnt),
        .md_op_cnt  (md_op_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {fa, fb, stall_f, stall_d, stall_e, flush_d, flush_e, flush_m, busy, done}
    logic [11:0] exp_q[$];
    string       name_q[$];
    int          total = 0;
    int          bad   = 0;

    function automatic logic [11:0] mk(
        input logic [1:0] fa, input logic [1:0] fb,
        input logic sf, input logic sd, input logic se,
        input logic fd, input logic fe, input logic fm,
        input logic bz, input logic dn);
        return {fa, fb, sf, sd, se, fd, fe, fm, bz, dn};
    endfunction

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [11:0] e;
            logic [11:0] g;
            string       n;
            e = exp_q.pop_front();
            n = name_q.pop_front();
            g = {forward_ae, forward_be, stall_f, stall_d, stall_e,
                 flush_d, flush_e, flush_m, md_busy, md_done};
            total++;
            if (g !== e) begin
                bad++;
                $display("FAIL %s: got=%b exp=%b (fa fb sf sd se fd fe fm busy done)",
                         n, g, e);
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string n, input logic [11:0] e);
        exp_q.push_back(e);
        name_q.push_back(n);
    endtask

    task automatic idle_inputs();
        rs1_d = '0; rs2_d = '0; rs1_e = '0; rs2_e = '0;
        rd_e = '0; rd_m = '0; rd_w = '0;
        load_e = 0; regwrite_m = 0; regwrite_w = 0;
        pcsrc_e = 0; md_start_e = 0;
    endtask

    localparam logic [11:0] ZERO = 12'b0;
    localparam logic [11:0] MDST = 12'b0000_1110_0100;
    localparam logic [11:0] MDBZ = 12'b0000_1110_0110;
    localparam logic [11:0] MDDN = 12'b0000_0000_0011;

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        reset_n = 1'b0;
        next_cycle();
        expect_out("reset", ZERO);
        next_cycle();
        reset_n = 1'b1;
        expect_out("post_reset", ZERO);

        next_cycle();
        rd_m = 5; regwrite_m = 1; rd_w = 5; regwrite_w = 1;
        rs1_e = 5; rs2_e = 5;
        expect_out("fwd_mem_pri", mk(2'b10, 2'b10, 0,0,0, 0,0,0, 0,0));
        next_cycle();
        regwrite_m = 0;
        expect_out("fwd_wb", mk(2'b01, 2'b01, 0,0,0, 0,0,0, 0,0));
        next_cycle();
        rs1_e = 0;
        expect_out("fwd_x0_a", mk(2'b00, 2'b01, 0,0,0, 0,0,0, 0,0));
        next_cycle();
        rs1_e = 5; rd_m = 3; regwrite_m = 1; rs2_e = 3;
        expect_out("fwd_split", mk(2'b01, 2'b10, 0,0,0, 0,0,0, 0,0));
        next_cycle();
        rd_m = 0; rd_w = 0; rs1_e = 0; rs2_e = 0;
        expect_out("fwd_rd_x0", ZERO);

        next_cycle();
        idle_inputs();
        load_e = 1; rd_e = 7; rs2_d = 7;
        expect_out("lw_rs2", mk(2'b00, 2'b00, 1,1,0, 0,1,0, 0,0));
        next_cycle();
        rd_e = 0;
        expect_out("lw_rd_x0", ZERO);
        next_cycle();
        rd_e = 9; rs1_d = 9; rs2_d = 1;
        expect_out("lw_rs1", mk(2'b00, 2'b00, 1,1,0, 0,1,0, 0,0));
        next_cycle();
        load_e = 0;
        expect_out("no_load", ZERO);

        next_cycle();
        idle_inputs();
        pcsrc_e = 1;
        expect_out("branch", mk(2'b00, 2'b00, 0,0,0, 1,1,0, 0,0));

        next_cycle();
        idle_inputs();
        md_start_e = 1;
        expect_out("md1_idle", MDST);
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            expect_out($sformatf("md1_busy%0d", i), MDBZ);
        end
        next_cycle();
        expect_out("md1_done", MDDN);

        // Back-to-back op with a load-use match in D: E must hold.
        next_cycle();
        load_e = 1; rd_e = 7; rs1_d = 7;
        expect_out("md2_idle_lw", MDST);
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            expect_out($sformatf("md2_busy_lw%0d", i), MDBZ);
        end
        next_cycle();
        expect_out("md2_done_lw", mk(2'b00, 2'b00, 1,1,0, 0,1,0, 1,1));
        next_cycle();
        idle_inputs();
        expect_out("md_idle", ZERO);

        next_cycle();
        md_start_e = 1;
        expect_out("md3_idle", MDST);
        next_cycle();
        expect_out("md3_busy", MDBZ);
        next_cycle();
        md_start_e = 0;
        reset_n = 0;
        #1;
        expect_out("rst_mid_busy", ZERO);
`ifdef HAZARD_PERF_EN
        total++;
        if ({stall_cnt, flush_cnt, md_op_cnt} !== 96'd0) begin
            bad++;
            $display("FAIL perf_reset: got=%0d/%0d/%0d exp=0/0/0",
                     stall_cnt, flush_cnt, md_op_cnt);
        end
`endif
        next_cycle();
        reset_n = 1;
        expect_out("rst_release", ZERO);
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            expect_out($sformatf("no_done%0d", i), ZERO);
        end

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(posedge clk);
        end
        if (exp_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: got=%0d pending exp=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
